// File: rtl/cell_pkg.sv
// Shared widths, mode encoding and default B3/S23 rule masks for the cellular-automaton cell.
package cell_pkg;

  localparam int NBR_W = 8;
  localparam int CNT_W = 4;

  typedef enum logic {
    MODE_EDIT = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  // Bit n of a mask selects the outcome for a cell with n live neighbours.
  localparam logic [8:0] DEF_BIRTH_MASK   = 9'b0_0000_1000;
  localparam logic [8:0] DEF_SURVIVE_MASK = 9'b0_0000_1100;

endpackage

// File: rtl/nbr_popcount.sv
// Counts live neighbours: number of set bits in the 8-bit neighbour vector (0..8).
module nbr_popcount
  import cell_pkg::*;
(
  input  logic [NBR_W-1:0] nbr,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NBR_W; i++) begin
      cnt = cnt + CNT_W'(nbr[i]);
    end
  end

endmodule

// File: rtl/c_cell.sv
// One Game-of-Life cell: user toggles in edit mode, rule-driven generations in run mode.
// Define USER_INPUT_SYNC_EN to pass userInput through a 2-flop synchroniser first.
module c_cell
  import cell_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK   = DEF_BIRTH_MASK,
  parameter logic [8:0] SURVIVE_MASK = DEF_SURVIVE_MASK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gameState,
  input  logic [NBR_W-1:0] neighbros,
  input  logic             userInput,
  output logic             status
);

  logic [CNT_W-1:0] cnt;
  logic             nxt;
  logic             u_in;
  logic             u_prev;
  logic             rise;
  mode_e            mode;

  nbr_popcount u_popcount (
    .nbr (neighbros),
    .cnt (cnt)
  );

`ifdef USER_INPUT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], userInput};
    end
  end

  assign u_in = sync_q[1];
`else
  assign u_in = userInput;
`endif

  assign mode = mode_e'(gameState);
  assign nxt  = status ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
  assign rise = u_in & ~u_prev;

  // u_prev follows u_in in both modes so a level held across a mode switch never looks like a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= 1'b0;
      u_prev <= 1'b0;
    end else begin
      u_prev <= u_in;
      if (mode == MODE_RUN) begin
        status <= nxt;
      end else if (rise) begin
        status <= ~status;
      end
    end
  end

endmodule

// File: tb/tb_c_cell.sv
// Self-checking bench for c_cell: directed scenarios plus random traffic against a rule-level model.
module tb_c_cell;

`ifdef USER_INPUT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       clk;
  logic       reset;
  logic       gameState;
  logic [7:0] neighbros;
  logic       userInput;
  logic       status;

  int checks;
  int failures;

  // Model state: cell value and history of userInput levels seen at each edge (newest first).
  logic m_status;
  bit   hist[$];

  c_cell dut (
    .clk       (clk),
    .reset     (reset),
    .gameState (gameState),
    .neighbros (neighbros),
    .userInput (userInput),
    .status    (status)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit hist_at(int k);
    if (k < hist.size()) return hist[k];
    return 1'b0;
  endfunction

  // Life rule stated directly: birth on exactly 3, survival on 2 or 3.
  function automatic logic life_rule(logic alive, logic [7:0] nbr);
    int n;
    n = $countones(nbr);
    if (alive) return (n == 2 || n == 3);
    return (n == 3);
  endfunction

  task automatic model_edge();
    bit rise;
    if (reset) begin
      m_status = 1'b0;
      hist.delete();
      return;
    end
    hist.push_front(userInput);
    if (hist.size() > 8) void'(hist.pop_back());
    rise = hist_at(SYNC) & ~hist_at(SYNC + 1);
    if (gameState) m_status = life_rule(m_status, neighbros);
    else if (rise) m_status = ~m_status;
  endtask

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then sample #1 later.
  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, status, m_status);
  endtask

  task automatic steps(string tag, int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_status  = 1'b0;
    reset     = 1'b1;
    gameState = 1'b0;
    neighbros = 8'h00;
    userInput = 1'b0;

    #2;
    check("reset_initial", status, 1'b0);
    steps("reset_held", 2);
    @(negedge clk);
    reset = 1'b0;

    // Edit toggle: held high toggles once
    userInput = 1'b1;
    steps("edit_hold", 5);
    check("edit_hold_once", status, 1'b1);
    userInput = 1'b0;
    steps("edit_low", 3);
    userInput = 1'b1;
    steps("edit_second", 4);
    check("edit_second_toggle", status, 1'b0);

    // Reset asserted with status=1 and no clock edge
    userInput = 1'b0;
    steps("edit_release", 3);
    userInput = 1'b1;
    steps("edit_set", 4);
    check("edit_set_one", status, 1'b1);
    userInput = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_status = 1'b0;
    hist.delete();
    check("reset_async", status, 1'b0);
    steps("reset_hold", 2);
    @(negedge clk);
    reset = 1'b0;

    // Birth / death
    gameState = 1'b1;
    neighbros = 8'b0000_0111;
    step("birth3");
    check("birth3_alive", status, 1'b1);
    neighbros = 8'b0000_1111;
    step("death4");
    check("death4_dead", status, 1'b0);

    // Survival / isolation
    neighbros = 8'b0000_0111;
    step("rebirth");
    neighbros = 8'b1000_0001;
    step("survive2");
    check("survive2_alive", status, 1'b1);
    neighbros = 8'b0000_0001;
    step("isolate1");
    check("isolate1_dead", status, 1'b0);
    neighbros = 8'hFF;
    step("dead8");
    check("dead8_stays", status, 1'b0);

    // Run mode ignores userInput; held level across switch gives no toggle
    neighbros = 8'h00;
    userInput = 1'b1;
    step("run_pulse");
    userInput = 1'b0;
    steps("run_pulse_low", 2);
    userInput = 1'b1;
    steps("run_held", 4);
    check("run_ignores_input", status, 1'b0);
    gameState = 1'b0;
    steps("switch_to_edit", 4);
    check("switch_no_toggle", status, 1'b0);
    gameState = 1'b1;
    steps("edit_run_edit", 2);
    gameState = 1'b0;
    steps("edit_run_edit_back", 3);
    check("held_across_modes", status, 1'b0);

    // Async reset mid-run with a stable count of 3
    gameState = 1'b1;
    neighbros = 8'b0101_0100;
    userInput = 1'b0;
    steps("run_cnt3", 2);
    check("run_cnt3_alive", status, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    m_status = 1'b0;
    hist.delete();
    check("reset_mid_run", status, 1'b0);
    steps("reset_mid_hold", 2);
    @(negedge clk);
    reset = 1'b0;
    step("resume_after_reset");
    check("resume_birth", status, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      gameState = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) neighbros = 8'($urandom);
      else neighbros = 8'(8'hFF >> $urandom_range(4, 7)) << $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0) userInput = ~userInput;
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
